// File: rtl/converter_if.sv
// Handshake and result bundle between a requester and the binary-to-BCD converter.
interface converter_if #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
);
    logic                  start;
    logic [IN_WIDTH-1:0]   number;
    logic [4*DIGITS-1:0]   bcd_number;
    logic                  busy;
    logic                  done;

    modport master (output start, number, input bcd_number, busy, done);
    modport slave  (input start, number, output bcd_number, busy, done);
endinterface

// File: rtl/converter.sv
// Sequential double-dabble binary-to-packed-BCD converter, one bit per clock.
//   state   | meaning
//   IDLE    | waiting for start; bcd_number holds last result
//   CONVERT | one add-3/shift iteration per edge, IN_WIDTH edges total
module converter #(
    parameter int IN_WIDTH = 16,
    parameter int DIGITS   = 5
) (
    input logic        clk,
    input logic        reset,
    converter_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam logic [4:0] LAST = 5'(IN_WIDTH - 1);

    typedef enum logic {IDLE, CONVERT} state_t;

    state_t                state_q, state_d;
    logic [IN_WIDTH-1:0]   operand_q, operand_d;
    logic [BW-1:0]         scratch_q, scratch_d;
    logic [BW-1:0]         adjusted, shifted;
    logic [4:0]            cnt_q, cnt_d;
    logic [BW-1:0]         bcd_q, bcd_d;
    logic                  done_q, done_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            operand_q <= '0;
            scratch_q <= '0;
            cnt_q     <= '0;
            bcd_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            operand_q <= operand_d;
            scratch_q <= scratch_d;
            cnt_q     <= cnt_d;
            bcd_q     <= bcd_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        adjusted = scratch_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch_q[4*i +: 4] >= 4'd5)
                adjusted[4*i +: 4] = scratch_q[4*i +: 4] + 4'd3;
        end
        shifted = {adjusted[BW-2:0], operand_q[IN_WIDTH-1]};
    end

    always_comb begin
        state_d   = state_q;
        operand_d = operand_q;
        scratch_d = scratch_q;
        cnt_d     = cnt_q;
        bcd_d     = bcd_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    operand_d = bus.number;
                    scratch_d = '0;
                    cnt_d     = '0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                scratch_d = shifted;
                operand_d = {operand_q[IN_WIDTH-2:0], 1'b0};
                cnt_d     = cnt_q + 5'd1;
                // Last iteration publishes the freshly shifted value directly.
                if (cnt_q == LAST) begin
                    bcd_d   = shifted;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
        endcase
    end

    assign bus.bcd_number = bcd_q;
    assign bus.busy       = (state_q == CONVERT);
    assign bus.done       = done_q;
endmodule

// File: tb/tb_converter.sv
// Directed and randomized checks for the sequential binary-to-BCD converter.
module tb_converter;
    logic clk = 1'b0;
    logic reset;
    int   errors = 0;
    int   checks = 0;

    converter_if #(.IN_WIDTH(16), .DIGITS(5)) bus ();
    converter #(.IN_WIDTH(16), .DIGITS(5)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch one conversion and observe it until done, without judging the outcome.
    task automatic do_conv(input logic [15:0] n, output logic [19:0] res,
                           output int busy_cycles, output int latency, output bit timeout);
        res = '0; busy_cycles = 0; latency = -1; timeout = 1'b1;
        bus.number = n;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (bus.busy === 1'b1) busy_cycles++;
            if (bus.done === 1'b1) begin
                res = bus.bcd_number;
                latency = k;
                timeout = 1'b0;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.start = 1'b0;
        bus.number = 16'd0;
        tick();
        tick();
        checks++;
        if (bus.bcd_number !== 20'h00000) begin errors++; $display("FAIL reset_bcd got=%h exp=%h", bus.bcd_number, 20'h0); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++;
        if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        bus.number = 16'd2555;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        bus.number = 16'hFFFF;
        checks++;
        if (bus.busy !== 1'b1) begin errors++; $display("FAIL basic_busy_e0 got=%b exp=1", bus.busy); end
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++;
            if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.bcd_number !== 20'h00000) begin
                errors++;
                $display("FAIL basic_during edge=%0d busy=%b done=%b bcd=%h exp busy=1 done=0 bcd=00000",
                         k, bus.busy, bus.done, bus.bcd_number);
            end
        end
        tick();
        checks++;
        if (bus.bcd_number !== 20'h02555) begin errors++; $display("FAIL basic_result got=%h exp=02555", bus.bcd_number); end
        checks++;
        if (bus.done !== 1'b1) begin errors++; $display("FAIL basic_done_e16 got=%b exp=1", bus.done); end
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL basic_busy_e16 got=%b exp=0", bus.busy); end
        tick();
        checks++;
        if (bus.done !== 1'b0 || bus.bcd_number !== 20'h02555) begin
            errors++;
            $display("FAIL basic_after done=%b bcd=%h exp done=0 bcd=02555", bus.done, bus.bcd_number);
        end
    endtask

    task automatic test_boundaries();
        logic [15:0] vin [4] = '{16'd0, 16'd9, 16'd10, 16'd65535};
        logic [19:0] vexp[4] = '{20'h00000, 20'h00009, 20'h00010, 20'h65535};
        logic [19:0] res;
        int bc, lat;
        bit to;
        for (int i = 0; i < 4; i++) begin
            do_conv(vin[i], res, bc, lat, to);
            checks++;
            if (to) begin errors++; $display("FAIL bound_timeout in=%0d got=no_done exp=done", vin[i]); end
            checks++;
            if (res !== vexp[i]) begin errors++; $display("FAIL bound_result in=%0d got=%h exp=%h", vin[i], res, vexp[i]); end
            checks++;
            if (lat !== 16 || bc !== 16) begin
                errors++;
                $display("FAIL bound_timing in=%0d latency=%0d busy=%0d exp 16/16", vin[i], lat, bc);
            end
            tick();
        end
    endtask

    task automatic test_ignore_restart();
        int dones = 0;
        bus.number = 16'd1234;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 16; k++) begin
            if (k == 5) begin bus.number = 16'd9999; bus.start = 1'b1; end
            tick();
            bus.start = 1'b0;
            if (k < 16 && bus.done === 1'b1) dones++;
        end
        checks++;
        if (bus.done !== 1'b1 || bus.bcd_number !== 20'h01234) begin
            errors++;
            $display("FAIL restart_result done=%b bcd=%h exp done=1 bcd=01234", bus.done, bus.bcd_number);
        end
        for (int k = 0; k < 25; k++) begin
            tick();
            if (bus.done === 1'b1 || bus.busy === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL restart_extra got=%0d extra busy/done cycles exp=0", dones); end
        checks++;
        if (bus.bcd_number !== 20'h01234) begin errors++; $display("FAIL restart_hold got=%h exp=01234", bus.bcd_number); end
    endtask

    task automatic test_reset_abort();
        logic [19:0] res;
        int bc, lat, dones = 0;
        bit to;
        bus.number = 16'd4321;
        bus.start  = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int k = 1; k <= 7; k++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (bus.bcd_number !== 20'h00000 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL abort_state bcd=%h busy=%b done=%b exp 00000/0/0", bus.bcd_number, bus.busy, bus.done);
        end
        do_conv(16'd4321, res, bc, lat, to);
        checks++;
        if (to || res !== 20'h04321 || lat !== 16) begin
            errors++;
            $display("FAIL abort_fresh timeout=%b got=%h latency=%0d exp=04321 latency=16", to, res, lat);
        end
        tick();
        for (int k = 0; k < 20; k++) begin
            if (bus.done === 1'b1) dones++;
            tick();
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL abort_spurious_done got=%0d exp=0", dones); end
    endtask

    task automatic test_back_to_back();
        logic exp_done;
        bus.number = 16'd100;
        bus.start  = 1'b1;
        tick();
        for (int k = 1; k <= 60; k++) begin
            tick();
            exp_done = (k == 16 || k == 33 || k == 50);
            checks++;
            if (bus.done !== exp_done || bus.busy !== !exp_done) begin
                errors++;
                $display("FAIL b2b_pulse edge=%0d done=%b busy=%b exp done=%b busy=%b",
                         k, bus.done, bus.busy, exp_done, !exp_done);
            end
            if (k >= 16) begin
                checks++;
                if (bus.bcd_number !== 20'h00100) begin
                    errors++;
                    $display("FAIL b2b_value edge=%0d got=%h exp=00100", k, bus.bcd_number);
                end
            end
        end
        bus.start = 1'b0;
        for (int k = 0; k < 25 && bus.busy === 1'b1; k++) tick();
        tick();
        checks++;
        if (bus.busy !== 1'b0) begin errors++; $display("FAIL b2b_drain busy=%b exp=0", bus.busy); end
    endtask

    task automatic test_random();
        logic [15:0] n;
        logic [19:0] res;
        int bc, lat, val;
        bit to, bad_digit;
        for (int i = 0; i < 1000; i++) begin
            n = 16'($urandom_range(0, 65535));
            do_conv(n, res, bc, lat, to);
            val = 0;
            bad_digit = 1'b0;
            for (int d = 4; d >= 0; d--) begin
                if (res[4*d +: 4] > 4'd9) bad_digit = 1'b1;
                val = val * 10 + int'(res[4*d +: 4]);
            end
            if (res[19:16] > 4'd6) bad_digit = 1'b1;
            checks++;
            if (to || bad_digit || val !== int'(n) || lat !== 16) begin
                errors++;
                $display("FAIL random in=%0d got=%h decoded=%0d latency=%0d exp value=%0d latency=16",
                         n, res, val, lat, n);
            end
            tick();
        end
    endtask

    initial begin
        reset = 1'b1;
        bus.start = 1'b0;
        bus.number = 16'd0;
        test_reset();
        test_basic();
        test_boundaries();
        test_ignore_restart();
        test_reset_abort();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/converter.md
CONVERTER -- requirements
Module: converter

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 16, giving the binary input width; only 16 is required to be supported.
REQ-002 SHALL have parameter DIGITS, default 5, giving the number of BCD output digits.
REQ-003 SHALL have port clk, input, 1 bit: rising-edge clock for all state.
REQ-004 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: request to convert the current `number`, sampled only while idle.
REQ-006 SHALL have port number, input, 16 bits: unsigned binary operand.
REQ-007 SHALL have port bcd_number, output, 20 bits: registered packed BCD result, digit 0 (ones) in [3:0] through digit 4 (ten-thousands) in [19:16].
REQ-008 SHALL have port busy, output, 1 bit: high while a conversion is in progress.
REQ-009 SHALL have port done, output, 1 bit: one-cycle pulse when bcd_number takes a new result.

Function
REQ-010 SHALL implement a sequential shift-add-3 (double-dabble) converter with states IDLE and CONVERT.
REQ-011 In IDLE with start=1 at a rising edge E0, it SHALL:
- capture `number` into an internal shift register;
- clear the 20-bit BCD scratch register;
- clear a 5-bit iteration counter;
- enter CONVERT with busy=1.
REQ-012 In CONVERT, each rising edge SHALL perform one iteration:
- add 3 to every scratch BCD digit whose value is >= 5;
- then shift {scratch, operand} left by 1 bit, MSB of the operand first.
REQ-013 After exactly 16 iterations (edges E1..E16), at edge E16 it SHALL:
- load the final scratch value into bcd_number;
- set done=1 for exactly one cycle;
- clear busy;
- return to IDLE.
REQ-014 Latency SHALL be 16 clock cycles from the start-sampling edge E0 to the edge E16 that updates bcd_number.
REQ-015 bcd_number SHALL hold its previous value unchanged throughout a conversion and while idle.
REQ-016 start SHALL be ignored while busy=1; no queuing, no restart.
REQ-017 Changes on `number` after E0 SHALL NOT affect the conversion in progress.
REQ-018 If start is held high continuously, a new conversion SHALL begin at E17, the first edge back in IDLE, and repeat back-to-back.
REQ-019 Each output digit SHALL be in the range 0..9; digit 4 SHALL be in the range 0..6 for 16-bit inputs.
REQ-020 Input 0 SHALL yield 0x00000; input 65535 SHALL yield 0x65535.
REQ-021 done and busy SHALL never be high in the same cycle after E16.

Reset
REQ-022 While reset=1 at a rising edge, the block SHALL enter IDLE with bcd_number=0, busy=0, done=0, counter=0, and scratch=0.
REQ-023 Reset SHALL take priority over start and over any conversion in progress; an aborted conversion SHALL NOT update bcd_number.
REQ-024 A start sampled at the first edge after reset deasserts SHALL be accepted normally.

Verification
REQ-025 Scenario 1: reset, then number=2555 with start pulsed for 1 cycle.
- Required: busy=1 for 16 cycles; at E16 bcd_number=0x02555 and done pulses once.
REQ-026 Scenario 2: boundary values, each run to completion.
- number=0 -> 0x00000.
- number=9 -> 0x00009.
- number=10 -> 0x00010.
- number=65535 -> 0x65535.
REQ-027 Scenario 3: start number=1234; at E5 change number to 9999 and pulse start again.
- Required: the second start is ignored; result 0x01234 at E16; no second done.
REQ-028 Scenario 4: start number=4321; assert reset at E8.
- Required: bcd_number=0x00000, busy=0, and no done pulse.
- Then a fresh start with number=4321 yields 0x04321 after 16 cycles.
REQ-029 Scenario 5: start held high with number=100.
- Required: done pulses at E16, E33, E50, ...; bcd_number stays 0x00100.
REQ-030 Scenario 6: random 16-bit values, ≥1000 iterations.
- Required: every decoded digit ≤9 and the decimal value equals the input.
